// File: rtl/mul_arbiter.sv
// Round-robin arbiter sharing one modular multiplier (a*b mod 3329) between
// N_REQ requesters. It tags each in-flight op with its owner id and routes the
// multiplier result back as a one-cycle rsp_valid pulse to that owner.
// A stop input halts new grants and lets the pipeline drain.
// Optional build macro MUL_ARB_STATS_EN adds a saturating accept counter (issue_cnt).
module mul_arbiter #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned W       = 12,
    parameter int unsigned MUL_LAT = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [N_REQ*W-1:0] req_a,
    input  logic [N_REQ*W-1:0] req_b,
    output logic [N_REQ-1:0]   rsp_valid,
    output logic [W-1:0]       rsp_r,
    input  logic               stop,
    output logic               idle,
    output logic               mul_en,
    output logic [W-1:0]       mul_a,
    output logic [W-1:0]       mul_b,
    input  logic [W-1:0]       mul_r
`ifdef MUL_ARB_STATS_EN
    ,
    output logic [15:0]        issue_cnt
`endif
);

    localparam int unsigned IdW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e               state_q, state_d;
    logic [IdW-1:0]       rr_ptr_q;
    logic                 iss_v_q;
    logic [IdW-1:0]       iss_id_q;
    logic [W-1:0]         mul_a_q, mul_b_q;
    logic [MUL_LAT-1:0]   tag_v_q;
    logic [IdW-1:0]       tag_id_q [MUL_LAT];
    logic [N_REQ-1:0]     rsp_valid_q;
    logic [W-1:0]         rsp_r_q;

    logic                 grant_found;
    logic [IdW-1:0]       grant_id;
    logic [W-1:0]         sel_a, sel_b;
    logic [N_REQ-1:0]     rsp_oh;
    logic                 pipe_busy;

    // Round-robin search from rr_ptr; reset, stop and drain suppress any grant.
    always_comb begin
        logic [IdW-1:0] idx;
        grant_found = 1'b0;
        grant_id    = '0;
        idx         = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = IdW'((32'(rr_ptr_q) + k) % N_REQ);
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_id    = idx;
            end
        end
        if (!rst_n || stop || (state_q == StDrain)) begin
            grant_found = 1'b0;
        end
    end

    // Decode grant to one-hot ready and mux the granted operands.
    always_comb begin
        req_ready = '0;
        sel_a     = '0;
        sel_b     = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (grant_found && (grant_id == IdW'(k))) begin
                req_ready[k] = 1'b1;
                sel_a        = req_a[k*W +: W];
                sel_b        = req_b[k*W +: W];
            end
        end
    end

    assign pipe_busy = iss_v_q | (|tag_v_q);

    // Owner one-hot for the op leaving the last tag stage.
    always_comb begin
        rsp_oh = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            rsp_oh[k] = tag_v_q[MUL_LAT-1] && (tag_id_q[MUL_LAT-1] == IdW'(k));
        end
    end

    // Next-state logic for the accept/drain FSM.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (grant_found) state_d = StRun;
            StRun: begin
                if (stop) begin
                    state_d = StDrain;
                end else if (!grant_found && !pipe_busy) begin
                    state_d = StIdle;
                end
            end
            StDrain: if (!pipe_busy) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State, round-robin pointer and issue stage registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            rr_ptr_q <= '0;
            iss_v_q  <= 1'b0;
            iss_id_q <= '0;
            mul_a_q  <= '0;
            mul_b_q  <= '0;
        end else begin
            state_q <= state_d;
            iss_v_q <= grant_found;
            if (grant_found) begin
                rr_ptr_q <= IdW'((32'(grant_id) + 1) % N_REQ);
                iss_id_q <= grant_id;
                mul_a_q  <= sel_a;
                mul_b_q  <= sel_b;
            end
        end
    end

    // Tag pipe advances in lockstep with the multiplier (only while mul_en is high).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tag_v_q <= '0;
            for (int unsigned i = 0; i < MUL_LAT; i++) tag_id_q[i] <= '0;
        end else if (mul_en) begin
            tag_v_q[0]  <= iss_v_q;
            tag_id_q[0] <= iss_id_q;
            for (int unsigned i = 1; i < MUL_LAT; i++) begin
                tag_v_q[i]  <= tag_v_q[i-1];
                tag_id_q[i] <= tag_id_q[i-1];
            end
        end
    end

    // Response register: capture mul_r and pulse the owner's valid bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid_q <= '0;
            rsp_r_q     <= '0;
        end else begin
            rsp_valid_q <= rsp_oh;
            if (tag_v_q[MUL_LAT-1]) rsp_r_q <= mul_r;
        end
    end

`ifdef MUL_ARB_STATS_EN
    logic [15:0] issue_cnt_q;

    // Saturating count of accepted operand pairs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            issue_cnt_q <= '0;
        end else if (grant_found && (issue_cnt_q != 16'hFFFF)) begin
            issue_cnt_q <= issue_cnt_q + 16'd1;
        end
    end

    assign issue_cnt = issue_cnt_q;
`endif

    assign mul_en    = pipe_busy;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_r     = rsp_r_q;
    assign idle      = (state_q == StIdle);

endmodule

// File: tb/tb_mul_arbiter.sv
// Self-checking bench for mul_arbiter: directed scenarios followed by random
// traffic, compared cycle by cycle against a transaction-level reference model.
module tb_mul_arbiter;

    localparam int N_REQ   = 4;
    localparam int W       = 12;
    localparam int MUL_LAT = 2;
    localparam int Q       = 3329;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [N_REQ-1:0]     req_valid;
    logic [N_REQ-1:0]     req_ready;
    logic [N_REQ*W-1:0]   req_a, req_b;
    logic [N_REQ-1:0]     rsp_valid;
    logic [W-1:0]         rsp_r;
    logic                 stop;
    logic                 idle;
    logic                 mul_en;
    logic [W-1:0]         mul_a, mul_b, mul_r;
`ifdef MUL_ARB_STATS_EN
    logic [15:0]          issue_cnt;
`endif

    always #5 clk = ~clk;

    mul_arbiter #(.N_REQ(N_REQ), .W(W), .MUL_LAT(MUL_LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_r     (rsp_r),
        .stop      (stop),
        .idle      (idle),
        .mul_en    (mul_en),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_r     (mul_r)
`ifdef MUL_ARB_STATS_EN
        ,
        .issue_cnt (issue_cnt)
`endif
    );

    // External multiplier: MUL_LAT register stages, advancing only while en is high.
    logic [W-1:0] mpipe [MUL_LAT];
    always @(posedge clk) begin
        if (mul_en) begin
            mpipe[0] <= W'((32'(mul_a) * 32'(mul_b)) % Q);
            for (int i = 1; i < MUL_LAT; i++) mpipe[i] <= mpipe[i-1];
        end
    end
    assign mul_r = mpipe[MUL_LAT-1];

    // Reference model state (transaction level).
    typedef struct {
        int due;
        int id;
        int r;
    } exp_t;

    exp_t q[$];
    int   t;
    int   rr;
    int   st;            // 0 idle, 1 running, 2 draining
    bit   hist [MUL_LAT+1];
    int   hold_r;
    int   acc_cnt;
    int   op_a [N_REQ];
    int   op_b [N_REQ];
    int   n_cmp;
    int   n_err;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, t, obs, exp);
        end
    endtask

    task automatic model_reset();
        rr      = 0;
        st      = 0;
        hold_r  = 0;
        acc_cnt = 0;
        q.delete();
        for (int k = 0; k <= MUL_LAT; k++) hist[k] = 1'b0;
    endtask

    // One clock cycle: apply operands, check outputs, advance the model.
    task automatic step();
        int   g;
        int   idx;
        bit   busy;
        logic [N_REQ-1:0] exp_rdy;
        logic [N_REQ-1:0] exp_rv;
        for (int i = 0; i < N_REQ; i++) begin
            req_a[i*W +: W] = W'(op_a[i]);
            req_b[i*W +: W] = W'(op_b[i]);
        end
        #2;
        if (!rst_n) begin
            check_eq("ready_in_reset", 32'(req_ready), 32'd0);
            model_reset();
        end else begin
            busy = 1'b0;
            for (int k = 0; k <= MUL_LAT; k++) busy = busy | hist[k];
            check_eq("idle", 32'(idle), 32'(st == 0));
            check_eq("mul_en", 32'(mul_en), 32'(busy));
`ifdef MUL_ARB_STATS_EN
            check_eq("issue_cnt", 32'(issue_cnt), 32'(acc_cnt));
`endif
            g = -1;
            if (!stop && st != 2) begin
                for (int k = 0; k < N_REQ; k++) begin
                    idx = (rr + k) % N_REQ;
                    if (g < 0 && ((req_valid >> idx) & 1) == 1) g = idx;
                end
            end
            exp_rdy = (g >= 0) ? N_REQ'(1 << g) : '0;
            check_eq("req_ready", 32'(req_ready), 32'(exp_rdy));

            exp_rv = '0;
            if (q.size() > 0 && q[0].due == t) exp_rv = N_REQ'(1 << q[0].id);
            check_eq("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
            if (exp_rv != '0) begin
                check_eq("rsp_r", 32'(rsp_r), 32'(q[0].r));
                hold_r = q[0].r;
                void'(q.pop_front());
            end else begin
                check_eq("rsp_r_hold", 32'(rsp_r), 32'(hold_r));
            end

            if (g >= 0) begin
                q.push_back('{due: t + MUL_LAT + 2, id: g, r: (op_a[g] * op_b[g]) % Q});
                rr = (g + 1) % N_REQ;
                if (acc_cnt < 65535) acc_cnt++;
            end
            case (st)
                0: if (g >= 0) st = 1;
                1: begin
                    if (stop) st = 2;
                    else if (g < 0 && !busy) st = 0;
                end
                default: if (!busy) st = 0;
            endcase
            for (int k = MUL_LAT; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = (g >= 0);
        end
        t++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        req_valid = '0;
        stop      = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        t     = 0;
        model_reset();
        rst_n     = 1'b0;
        stop      = 1'b0;
        req_valid = '0;
        for (int i = 0; i < N_REQ; i++) begin
            op_a[i] = 0;
            op_b[i] = 0;
        end
        @(posedge clk);
        #1;
        step();
        step();
        rst_n = 1'b1;
        idle_cycles(2);

        // Single op with operands congruent to -1.
        req_valid = 4'b0001;
        op_a[0]   = 3328;
        op_b[0]   = 3328;
        step();
        idle_cycles(7);

        // All four requesters continuously valid for 8 cycles.
        for (int i = 0; i < N_REQ; i++) begin
            op_a[i] = i + 1;
            op_b[i] = (1665 * (i + 1)) % Q;
        end
        req_valid = 4'b1111;
        for (int c = 0; c < 8; c++) step();
        idle_cycles(7);

        // Fairness between two requesters.
        req_valid = 4'b0101;
        for (int c = 0; c < 8; c++) step();
        idle_cycles(7);

        // Three accepts, then stop asserted together with all requests.
        req_valid = 4'b1111;
        for (int c = 0; c < 3; c++) step();
        stop = 1'b1;
        for (int c = 0; c < 8; c++) step();
        idle_cycles(4);

        // Reset one cycle after two accepts; dropped ops must never respond.
        req_valid = 4'b0110;
        step();
        step();
        req_valid = '0;
        step();
        rst_n = 1'b0;
        step();
        rst_n     = 1'b1;
        req_valid = 4'b1111;
        step();
        idle_cycles(7);

        // Random traffic with occasional stop and reset.
        for (int c = 0; c < 600; c++) begin
            req_valid = N_REQ'($urandom_range(0, 15));
            stop      = ($urandom_range(0, 9) == 0);
            rst_n     = ($urandom_range(0, 99) != 0);
            for (int i = 0; i < N_REQ; i++) begin
                op_a[i] = int'($urandom_range(0, 4095));
                op_b[i] = int'($urandom_range(0, 4095));
            end
            step();
        end
        rst_n = 1'b1;
        idle_cycles(8);
        check_eq("all_responses_seen", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
